// File: rtl/calc_cordic_pkg.sv
// Shared constants, opcode map, angle tables and shift schedule for the CORDIC calculator.
package calc_cordic_pkg;

   localparam logic [3:0] OP_SIN   = 4'd0;
   localparam logic [3:0] OP_COS   = 4'd1;
   localparam logic [3:0] OP_ATAN  = 4'd2;
   localparam logic [3:0] OP_MOD   = 4'd3;
   localparam logic [3:0] OP_MULT  = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd5;
   localparam logic [3:0] OP_SINH  = 4'd6;
   localparam logic [3:0] OP_COSH  = 4'd7;
   localparam logic [3:0] OP_ATANH = 4'd8;
   localparam logic [3:0] OP_MODH  = 4'd9;

   // Q16.16 scale factors: circular gain compensation K and hyperbolic 1/Kh.
   localparam logic [31:0] K_CIRC_Q = 32'h0000_9B75;
   localparam logic [31:0] KH_INV_Q = 32'h0001_3520;
   localparam logic [31:0] ONE_Q    = 32'h0001_0000;

   typedef enum logic [1:0] {
      MODE_CIRC = 2'd0,
      MODE_LIN  = 2'd1,
      MODE_HYP  = 2'd2
   } cordic_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Coordinate system used by an opcode; unused opcodes run harmlessly in linear mode.
   function automatic cordic_mode_e op_mode(input logic [3:0] op);
      cordic_mode_e m;
      case (op)
         OP_SIN, OP_COS, OP_ATAN, OP_MOD:      m = MODE_CIRC;
         OP_SINH, OP_COSH, OP_ATANH, OP_MODH:  m = MODE_HYP;
         default:                              m = MODE_LIN;
      endcase
      return m;
   endfunction

   // Vectoring opcodes drive y to zero; all others drive z to zero.
   function automatic logic op_vectoring(input logic [3:0] op);
      logic v;
      case (op)
         OP_ATAN, OP_MOD, OP_DIV, OP_ATANH, OP_MODH: v = 1'b1;
         default:                                    v = 1'b0;
      endcase
      return v;
   endfunction

   // Hyperbolic shift schedule 1,2,3,4,4,5..12,13,13,14 (repeats keep convergence).
   function automatic logic [3:0] hyp_shift(input logic [3:0] i);
      logic [3:0] s;
      if (i < 4'd4) begin
         s = i + 4'd1;
      end else if (i <= 4'd13) begin
         s = i;
      end else begin
         s = i - 4'd1;
      end
      return s;
   endfunction

   // atan(2^-i) in Q16.16.
   function automatic logic [31:0] atan_lut(input logic [3:0] i);
      logic [31:0] e;
      case (i)
         4'd0:    e = 32'd51472;
         4'd1:    e = 32'd30386;
         4'd2:    e = 32'd16055;
         4'd3:    e = 32'd8150;
         4'd4:    e = 32'd4091;
         4'd5:    e = 32'd2047;
         4'd6:    e = 32'd1024;
         4'd7:    e = 32'd512;
         4'd8:    e = 32'd256;
         4'd9:    e = 32'd128;
         4'd10:   e = 32'd64;
         4'd11:   e = 32'd32;
         4'd12:   e = 32'd16;
         4'd13:   e = 32'd8;
         4'd14:   e = 32'd4;
         4'd15:   e = 32'd2;
         default: e = 32'd0;
      endcase
      return e;
   endfunction

   // atanh(2^-s) in Q16.16, indexed by the shift amount (s=0 never used).
   function automatic logic [31:0] atanh_lut(input logic [3:0] s);
      logic [31:0] e;
      case (s)
         4'd1:    e = 32'd35999;
         4'd2:    e = 32'd16739;
         4'd3:    e = 32'd8235;
         4'd4:    e = 32'd4101;
         4'd5:    e = 32'd2049;
         4'd6:    e = 32'd1024;
         4'd7:    e = 32'd512;
         4'd8:    e = 32'd256;
         4'd9:    e = 32'd128;
         4'd10:   e = 32'd64;
         4'd11:   e = 32'd32;
         4'd12:   e = 32'd16;
         4'd13:   e = 32'd8;
         4'd14:   e = 32'd4;
         default: e = 32'd0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/cordic_step.sv
// One combinational CORDIC micro-rotation for circular, linear or hyperbolic mode.
module cordic_step
   import calc_cordic_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] y_i,
   input  logic signed [WIDTH-1:0] z_i,
   input  cordic_mode_e            mode_i,
   input  logic                    d_pos_i,
   input  logic [3:0]              shift_i,
   input  logic signed [WIDTH-1:0] e_i,
   output logic signed [WIDTH-1:0] x_o,
   output logic signed [WIDTH-1:0] y_o,
   output logic signed [WIDTH-1:0] z_o
);

   logic signed [WIDTH-1:0] xs_s;
   logic signed [WIDTH-1:0] ys_s;

   assign xs_s = x_i >>> shift_i;
   assign ys_s = y_i >>> shift_i;

   // Apply the rotation direction to y/z and the mode-dependent coupling into x.
   always_comb begin
      x_o = x_i;
      y_o = y_i;
      z_o = z_i;
      if (d_pos_i) begin
         y_o = y_i + xs_s;
         z_o = z_i - e_i;
      end else begin
         y_o = y_i - xs_s;
         z_o = z_i + e_i;
      end
      case (mode_i)
         MODE_CIRC: x_o = d_pos_i ? (x_i - ys_s) : (x_i + ys_s);
         MODE_HYP:  x_o = d_pos_i ? (x_i + ys_s) : (x_i - ys_s);
         default:   x_o = x_i;
      endcase
   end

endmodule

// File: rtl/calc_cordic_top.sv
// Iterative multi-function CORDIC calculator: FSM, vector registers and result scaling.
module calc_cordic_top
   import calc_cordic_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ITERATIONS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [3:0]              operation,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   output logic signed [WIDTH-1:0] result,
   output logic                    done
);

   localparam int CW = $clog2(ITERATIONS + 1);

   state_e                  state_q, state_d;
   logic [3:0]              op_q, op_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic signed [WIDTH-1:0] result_q, result_d;
   logic                    done_q, done_d;

   cordic_mode_e            mode_s;
   logic [3:0]              idx_s;
   logic [3:0]              shift_s;
   logic                    d_pos_s;
   logic signed [WIDTH-1:0] e_s;
   logic signed [WIDTH-1:0] x_step_s, y_step_s, z_step_s;
   logic signed [2*WIDTH-1:0] x_ext_s, k_ext_s, kh_ext_s;
   logic signed [WIDTH-1:0] mod_res_s, modh_res_s;

   assign mode_s  = op_mode(op_q);
   assign idx_s   = 4'(cnt_q);
   assign d_pos_s = op_vectoring(op_q) ? y_q[WIDTH-1] : ~z_q[WIDTH-1];

   // Pick the shift amount and angle/step constant for the current iteration.
   always_comb begin
      shift_s = idx_s;
      e_s     = '0;
      case (mode_s)
         MODE_CIRC: begin
            shift_s = idx_s;
            e_s     = WIDTH'(atan_lut(idx_s));
         end
         MODE_HYP: begin
            shift_s = hyp_shift(idx_s);
            e_s     = WIDTH'(atanh_lut(hyp_shift(idx_s)));
         end
         default: begin
            shift_s = idx_s;
            e_s     = WIDTH'(ONE_Q >> idx_s);
         end
      endcase
   end

   cordic_step #(.WIDTH(WIDTH)) u_step (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .mode_i  (mode_s),
      .d_pos_i (d_pos_s),
      .shift_i (shift_s),
      .e_i     (e_s),
      .x_o     (x_step_s),
      .y_o     (y_step_s),
      .z_o     (z_step_s)
   );

   // Gain compensation for the modulus results: full product, keep bits [WIDTH+15:16].
   assign x_ext_s    = {{WIDTH{x_q[WIDTH-1]}}, x_q};
   assign k_ext_s    = (2*WIDTH)'(K_CIRC_Q);
   assign kh_ext_s   = (2*WIDTH)'(KH_INV_Q);
   assign mod_res_s  = WIDTH'((x_ext_s * k_ext_s) >>> 16);
   assign modh_res_s = WIDTH'((x_ext_s * kh_ext_s) >>> 16);

   // Next-state logic: accept, iterate, then select and publish the result.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = done_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (enable) begin
               op_d    = operation;
               cnt_d   = '0;
               done_d  = 1'b0;
               state_d = ST_RUN;
               case (operation)
                  OP_SIN, OP_COS: begin
                     x_d = WIDTH'(K_CIRC_Q);
                     y_d = '0;
                     z_d = z_in;
                  end
                  OP_SINH, OP_COSH: begin
                     x_d = WIDTH'(KH_INV_Q);
                     y_d = '0;
                     z_d = z_in;
                  end
                  OP_MULT: begin
                     x_d = x_in;
                     y_d = '0;
                     z_d = z_in;
                  end
                  default: begin
                     x_d = x_in;
                     y_d = y_in;
                     z_d = '0;
                  end
               endcase
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (cnt_q == CW'(ITERATIONS)) begin
               state_d = ST_FINISH;
            end else begin
               x_d   = x_step_s;
               y_d   = y_step_s;
               z_d   = z_step_s;
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_FINISH: begin
            case (op_q)
               OP_SIN, OP_MULT, OP_SINH:      result_d = y_q;
               OP_COS, OP_COSH:               result_d = x_q;
               OP_ATAN, OP_DIV, OP_ATANH:     result_d = z_q;
               OP_MOD:                        result_d = mod_res_s;
               OP_MODH:                       result_d = modh_res_s;
               default:                       result_d = '0;
            endcase
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= 4'd0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_calc_cordic_top.sv
// Self-checking bench for calc_cordic_top against a real-arithmetic reference model.
module tb_calc_cordic_top;
   import calc_cordic_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               enable;
   logic [3:0]         operation;
   logic signed [31:0] x_in, y_in, z_in;
   logic signed [31:0] result;
   logic               done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   calc_cordic_top #(.WIDTH(32), .ITERATIONS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .operation (operation),
      .x_in      (x_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .result    (result),
      .done      (done)
   );

   function automatic logic signed [31:0] to_q(input real r);
      return $rtoi(r * 65536.0);
   endfunction

   function automatic real from_q(input logic signed [31:0] v);
      return $itor(v) / 65536.0;
   endfunction

   function automatic real rnd(input real lo, input real hi);
      return lo + (hi - lo) * $itor($urandom_range(0, 10000)) / 10000.0;
   endfunction

   // Mathematical meaning of each opcode, on the quantized operands.
   function automatic real ref_val(input logic [3:0] op, input real xr, input real yr, input real zr);
      real r;
      case (op)
         OP_SIN:   r = $sin(zr);
         OP_COS:   r = $cos(zr);
         OP_ATAN:  r = $atan(yr / xr);
         OP_MOD:   r = $sqrt(xr * xr + yr * yr);
         OP_MULT:  r = xr * zr;
         OP_DIV:   r = yr / xr;
         OP_SINH:  r = $sinh(zr);
         OP_COSH:  r = $cosh(zr);
         OP_ATANH: r = $atanh(yr / xr);
         OP_MODH:  r = $sqrt(xr * xr - yr * yr);
         default:  r = 0.0;
      endcase
      return r;
   endfunction

   task automatic check_val(input string tag, input real got, input real exp, input real tol);
      n_checks++;
      if (got - exp > tol || exp - got > tol) begin
         n_errors++;
         $display("FAIL %s: got %f expected %f (tol %f)", tag, got, exp, tol);
      end
   endtask

   // Issue one operation, measure latency in edges after the accepting edge, check result.
   task automatic run_op(input string tag, input logic [3:0] op, input real xr, input real yr,
                         input real zr, input bit poke, output real res);
      int lat;
      @(negedge clk);
      operation = op;
      x_in      = to_q(xr);
      y_in      = to_q(yr);
      z_in      = to_q(zr);
      enable    = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (poke && lat == 5) begin
            enable    = 1'b1;
            operation = OP_COS;
            z_in      = 32'sd0;
         end else begin
            enable = 1'b0;
         end
      end
      check_val({tag, " latency"}, $itor(lat), 18.0, 0.0);
      res = from_q(result);
      check_val(tag, res, ref_val(op, from_q(to_q(xr)), from_q(to_q(yr)), from_q(to_q(zr))), 0.001);
   endtask

   initial begin
      real        res;
      logic [3:0] op;
      real        xr, yr, zr;

      rst = 1'b1; enable = 1'b0; operation = 4'd0;
      x_in = 32'sd0; y_in = 32'sd0; z_in = 32'sd0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset done", $itor(done), 0.0, 0.0);
      check_val("reset result", from_q(result), 0.0, 0.0);
      @(negedge clk);
      rst = 1'b0;

      run_op("sin 0.5236", OP_SIN, 0.0, 0.0, 0.523599, 1'b0, res);
      check_val("sin abs", res, 0.5, 0.001);
      repeat (5) @(posedge clk);
      #1;
      check_val("done hold", $itor(done), 1.0, 0.0);
      check_val("result hold", from_q(result), 0.5, 0.001);

      run_op("cos 0", OP_COS, 0.0, 0.0, 0.0, 1'b0, res);
      check_val("cos abs", res, 1.0, 0.001);
      run_op("atan 1,1", OP_ATAN, 1.0, 1.0, 0.0, 1'b0, res);
      check_val("atan abs", res, 0.785398, 0.001);
      run_op("mod 3,4", OP_MOD, 3.0, 4.0, 0.0, 1'b0, res);
      check_val("mod abs", res, 5.0, 0.001);
      run_op("mult 3*1.5", OP_MULT, 3.0, 0.0, 1.5, 1'b0, res);
      check_val("mult abs", res, 4.5, 0.001);
      run_op("div 1/4", OP_DIV, 4.0, 1.0, 0.0, 1'b0, res);
      check_val("div abs", res, 0.25, 0.001);
      run_op("sinh 1", OP_SINH, 0.0, 0.0, 1.0, 1'b0, res);
      check_val("sinh abs", res, 1.175201, 0.001);
      run_op("cosh 1", OP_COSH, 0.0, 0.0, 1.0, 1'b0, res);
      check_val("cosh abs", res, 1.543081, 0.001);
      run_op("atanh 1,0.5", OP_ATANH, 1.0, 0.5, 0.0, 1'b0, res);
      check_val("atanh abs", res, 0.549306, 0.001);
      run_op("modh 5,3", OP_MODH, 5.0, 3.0, 0.0, 1'b0, res);
      check_val("modh abs", res, 4.0, 0.001);

      for (int k = 0; k <= 32; k++) begin
         run_op("modh sweep", OP_MODH, 2.0 + 0.25 * $itor(k), 1.0, 0.0, 1'b0, res);
      end

      // enable during RUN must not restart or retarget the operation
      run_op("sin with mid-run enable", OP_SIN, 0.0, 0.0, 0.523599, 1'b1, res);
      check_val("mid-run enable ignored", res, 0.5, 0.001);

      run_op("opcode 15", 4'd15, 1.0, 1.0, 1.0, 1'b0, res);
      check_val("opcode 15 zero", res, 0.0, 0.0);

      // prime a nonzero result, then abort an operation with reset
      run_op("cosh before rst", OP_COSH, 0.0, 0.0, 0.5, 1'b0, res);
      @(negedge clk);
      operation = OP_SIN; z_in = to_q(1.0); enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("midrun rst done", $itor(done), 0.0, 0.0);
      check_val("midrun rst result", from_q(result), 0.0, 0.0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_val("idle after rst", $itor(done), 0.0, 0.0);
      run_op("sin after rst", OP_SIN, 0.0, 0.0, 0.523599, 1'b0, res);

      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 15));
         xr = rnd(1.0, 4.0);
         yr = rnd(-4.0, 4.0);
         zr = 0.0;
         case (op)
            OP_SIN, OP_COS:     zr = rnd(-1.5, 1.5);
            OP_MULT: begin
               xr = rnd(-4.0, 4.0);
               zr = rnd(-1.9, 1.9);
            end
            OP_DIV:             yr = xr * rnd(-1.8, 1.8);
            OP_SINH, OP_COSH:   zr = rnd(-1.0, 1.0);
            OP_ATANH, OP_MODH:  yr = xr * rnd(-0.75, 0.75);
            default:            zr = rnd(-1.0, 1.0);
         endcase
         run_op($sformatf("random op%0d", op), op, xr, yr, zr, 1'b0, res);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/calc_cordic_top.md
Name: calc_cordic_top

Overview:
Iterative multi-function CORDIC calculator on signed Q16.16 fixed point. It covers circular, linear and hyperbolic modes, each in rotation or vectoring form, and runs one micro-rotation per clock. An operation is started with a one-cycle enable. The block returns a single scalar result, with a done flag that stays high until the next operation is accepted. This is the top-level compute block of the calculator datapath.

Parameters:
WIDTH, 32, data width of every operand and of the result; format is Q(WIDTH-16).16 two's complement.
ITERATIONS, 16, number of micro-rotation steps per operation, all modes.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
enable  input  1  start strobe; sampled only in IDLE
operation  input  4  opcode: 0 SIN, 1 COS, 2 ATAN, 3 MOD, 4 MULT, 5 DIV, 6 SINH, 7 COSH, 8 ATANH, 9 MODH, 10-15 unused
x_in  input  WIDTH  signed Q16.16 operand x
y_in  input  WIDTH  signed Q16.16 operand y
z_in  input  WIDTH  signed Q16.16 operand z (angle in radians, or multiplier)
result  output  WIDTH  signed Q16.16 result, held stable while done=1
done  output  1  result valid; held high until the next accepted enable

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset: state←IDLE; x, y, z and iteration counter←0; result←0; done←0. Reset mid-operation aborts the operation; nothing of it persists.
- States:
  - IDLE/DONE: enable=1 at a rising edge latches operation, x_in, y_in and z_in, loads the initial vector, clears done, moves to RUN, and sets counter←0.
  - RUN: one micro-rotation per edge. After ITERATIONS steps, move to FINISH.
  - FINISH: compute and select result, set done←1, move to DONE.
  - DONE behaves like IDLE.
- Latency: done rises on the (ITERATIONS+2)th rising edge after the accepting edge, for every opcode. enable while in RUN or FINISH is ignored.
- Step direction:
  - Rotation mode: d=sign(z), d=+1 when z≥0.
  - Vectoring mode: d=−sign(y), d=+1 when y<0.
- Step update:
  - x←x−m·d·(y>>>s)
  - y←y+d·(x>>>s)
  - z←z−d·e(s)
  - Shifts are arithmetic. No saturation; wrap-around on overflow.
- Mode constants:
  - Circular: m=+1, s=0..15, e=atan(2^−s).
  - Linear: m=0, x unchanged, s=0..15, e=2^−s.
  - Hyperbolic: m=−1, shift sequence 1,2,3,4,4,5,...,12,13,13,14 (16 steps; 4 and 13 repeated), e=atanh(2^−s).
- Initial vector and result per opcode:
  - SIN/COS (circular rotation): x=K=0x00009B75 (0.607253), y=0, z=z_in. Result SIN=y, COS=x. Valid for |z_in|≤π/2.
  - ATAN (circular vectoring): x=x_in, y=y_in, z=0. Result z. Valid for x_in>0.
  - MOD (circular vectoring): same start as ATAN. Result = (x·K) in Q16.16 (full product, bits [47:16]).
  - MULT (linear rotation): x=x_in, y=0, z=z_in. Result y = x_in·z_in. Valid for |z_in|<2.
  - DIV (linear vectoring): x=x_in, y=y_in, z=0. Result z = y_in/x_in. Valid for x_in>0 and |y/x|<2.
  - SINH/COSH (hyperbolic rotation): x=1/Kh=0x00013520 (1.207497), y=0, z=z_in. Result SINH=y, COSH=x. Valid for |z_in|≤1.1.
  - ATANH (hyperbolic vectoring): x=x_in, y=y_in, z=0. Result z. Valid for x_in>0 and |y/x|<0.8.
  - MODH (hyperbolic vectoring): same start as ATANH. Result = x·(1/Kh) = sqrt(x_in²−y_in²).
- Unused opcodes: result=0, done asserted with the normal latency.
- Accuracy: |error| ≤ 0.001 inside the valid ranges.

Decomposition:
- Shared package calc_cordic_pkg holds:
  - opcode localparams
  - K, 1/Kh and the Q16.16 atan and atanh tables
  - the hyperbolic shift-sequence function
- Natural sub-module cordic_step: one combinational micro-rotation with inputs (x, y, z, m, d, shift, e) and outputs (x', y', z'). The top holds the FSM, registers, and initial/final scaling.

Test Plan:
- SIN z=0.523599, then COS z=0 → 0.5 and 1.0 (±0.001). done rises exactly 18 edges after the accepting edge and stays high.
- ATAN x=1,y=1 → 0.785398. MOD x=3,y=4 → 5.0. MULT x=3,z=1.5 → 4.5. DIV x=4,y=1 → 0.25.
- SINH z=1.0 → 1.175201. COSH z=1.0 → 1.543081. ATANH x=1,y=0.5 → 0.549306.
- MODH sweep x=2..10 step 0.25 with y=1 → sqrt(x²−1); for example x=5,y=3 → 4.0. All errors must be < 0.001.
- enable pulsed mid-RUN is ignored, so the first result is unchanged. Opcode 15 → result 0 with done after 18 edges.
- rst asserted mid-RUN → next edge: done=0, result=0, state IDLE. A fresh SIN then completes correctly.
